// File: rtl/cpu_ctl_pkg.sv
// Shared constants for the phase-3 control sequencer: opcodes, FSM steps,
// control-bundle bit positions and instruction classes.
package cpu_ctl_pkg;

  localparam int CTL_W = 30;
  localparam int OPW   = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_AND  = 5'b01001;
  localparam logic [OPW-1:0] OP_OR   = 5'b01010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
  localparam logic [OPW-1:0] OP_IN   = 5'b10101;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  localparam int CTL_GRA       = 0;
  localparam int CTL_GRB       = 1;
  localparam int CTL_GRC       = 2;
  localparam int CTL_RIN       = 3;
  localparam int CTL_ROUT      = 4;
  localparam int CTL_BAOUT     = 5;
  localparam int CTL_COUT      = 6;
  localparam int CTL_PCOUT     = 7;
  localparam int CTL_PCIN      = 8;
  localparam int CTL_INCPC     = 9;
  localparam int CTL_MARIN     = 10;
  localparam int CTL_MDRIN     = 11;
  localparam int CTL_MDROUT    = 12;
  localparam int CTL_READ      = 13;
  localparam int CTL_WRITE     = 14;
  localparam int CTL_IRIN      = 15;
  localparam int CTL_YIN       = 16;
  localparam int CTL_ZHIGHIN   = 17;
  localparam int CTL_ZLOWIN    = 18;
  localparam int CTL_ZHIGHOUT  = 19;
  localparam int CTL_ZLOWOUT   = 20;
  localparam int CTL_HIIN      = 21;
  localparam int CTL_LOIN      = 22;
  localparam int CTL_HIOUT     = 23;
  localparam int CTL_LOOUT     = 24;
  localparam int CTL_CONIN     = 25;
  localparam int CTL_INPORTIN  = 26;
  localparam int CTL_INPORTOUT = 27;
  localparam int CTL_OUTPORTIN = 28;
  localparam int CTL_SPARE     = 29;

  typedef enum logic [3:0] {
    CLS_REG, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LDST, CLS_BR,
    CLS_JR, CLS_JAL, CLS_IO, CLS_MOVE, CLS_NOP, CLS_HALT
  } op_class_e;

  // Default successor of an execute step; the sequencer overrides it when an
  // instruction finishes.
  function automatic state_e next_step(state_e s);
    case (s)
      S_T3:    return S_T4;
      S_T4:    return S_T5;
      S_T5:    return S_T6;
      S_T6:    return S_T7;
      default: return S_T0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_op_class_decode.sv
// Opcode-to-instruction-class decoder. Honours CU_MULDIV_EN: when undefined,
// mul/div fall through to the nop class.
module op_class_decode
  import cpu_ctl_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output op_class_e      cls_o
);

  always_comb begin
    cls_o = CLS_NOP;
    case (opcode_i)
      OP_LD, OP_LDI, OP_ST:                 cls_o = CLS_LDST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:        cls_o = CLS_REG;
      OP_ADDI, OP_ANDI, OP_ORI:             cls_o = CLS_IMM;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                       cls_o = CLS_MULDIV;
`endif
      OP_NEG, OP_NOT:                       cls_o = CLS_UNARY;
      OP_BR:                                cls_o = CLS_BR;
      OP_JR:                                cls_o = CLS_JR;
      OP_JAL:                               cls_o = CLS_JAL;
      OP_IN, OP_OUT:                        cls_o = CLS_IO;
      OP_MFHI, OP_MFLO:                     cls_o = CLS_MOVE;
      OP_HALT:                              cls_o = CLS_HALT;
      default:                              cls_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, opcode-driven execute T3-T7.
// Optional mul/div sequencing is enabled by defining CU_MULDIV_EN.
module control_unit
  import cpu_ctl_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             stop,
  output logic [CTL_W-1:0] ctl,
  output logic [OPW-1:0]   alu_op,
  output logic             run
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  op_class_e      cls;
  logic           step_done;
  logic           unused_ir;

  assign unused_ir = ^ir[26:0];

  op_class_decode u_decode (
    .opcode_i (op_q),
    .cls_o    (cls)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_RESET;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign run = (state_q != S_RESET) && (state_q != S_HALT);

  always_comb begin
    // NOTE: every output and next-state variable is defaulted first so that
    // no path through the case statements can infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    ctl       = '0;
    alu_op    = '0;
    step_done = 1'b0;

    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        ctl[CTL_PCOUT] = 1'b1; ctl[CTL_MARIN] = 1'b1;
        ctl[CTL_INCPC] = 1'b1; ctl[CTL_ZLOWIN] = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_PCIN] = 1'b1;
        ctl[CTL_READ]    = 1'b1; ctl[CTL_MDRIN] = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        ctl[CTL_MDROUT] = 1'b1; ctl[CTL_IRIN] = 1'b1;
        op_d    = ir[31:27];
        state_d = S_T3;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = next_step(state_q);
        case (cls)
          CLS_REG, CLS_IMM: begin
            case (state_q)
              S_T3: begin
                ctl[CTL_GRB] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_YIN] = 1'b1;
              end
              S_T4: begin
                if (cls == CLS_IMM) begin
                  ctl[CTL_COUT] = 1'b1;
                end else begin
                  ctl[CTL_GRC] = 1'b1; ctl[CTL_ROUT] = 1'b1;
                end
                ctl[CTL_ZLOWIN] = 1'b1;
                alu_op = op_q;
              end
              default: begin
                ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
                step_done = 1'b1;
              end
            endcase
          end
          CLS_UNARY: begin
            if (state_q == S_T3) begin
              ctl[CTL_GRB] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_ZLOWIN] = 1'b1;
              alu_op = op_q;
            end else begin
              ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
              step_done = 1'b1;
            end
          end
          CLS_MULDIV: begin
            case (state_q)
              S_T3: begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_YIN] = 1'b1;
              end
              S_T4: begin
                ctl[CTL_GRB] = 1'b1; ctl[CTL_ROUT] = 1'b1;
                ctl[CTL_ZHIGHIN] = 1'b1; ctl[CTL_ZLOWIN] = 1'b1;
                alu_op = op_q;
              end
              S_T5: begin
                ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_LOIN] = 1'b1;
              end
              default: begin
                ctl[CTL_ZHIGHOUT] = 1'b1; ctl[CTL_HIIN] = 1'b1;
                step_done = 1'b1;
              end
            endcase
          end
          CLS_LDST: begin
            // Effective address is always Rb + C, computed with the ALU add.
            case (state_q)
              S_T3: begin
                ctl[CTL_GRB] = 1'b1; ctl[CTL_BAOUT] = 1'b1; ctl[CTL_YIN] = 1'b1;
              end
              S_T4: begin
                ctl[CTL_COUT] = 1'b1; ctl[CTL_ZLOWIN] = 1'b1;
                alu_op = OP_ADD;
              end
              S_T5: begin
                ctl[CTL_ZLOWOUT] = 1'b1;
                if (op_q == OP_LDI) begin
                  ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
                  step_done = 1'b1;
                end else begin
                  ctl[CTL_MARIN] = 1'b1;
                end
              end
              S_T6: begin
                if (op_q == OP_ST) begin
                  ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1;
                end else begin
                  ctl[CTL_READ] = 1'b1;
                end
                ctl[CTL_MDRIN] = 1'b1;
              end
              default: begin
                if (op_q == OP_ST) begin
                  ctl[CTL_WRITE] = 1'b1;
                end else begin
                  ctl[CTL_MDROUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
                end
                step_done = 1'b1;
              end
            endcase
          end
          CLS_BR: begin
            case (state_q)
              S_T3: begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_CONIN] = 1'b1;
              end
              S_T4: begin
                ctl[CTL_PCOUT] = 1'b1; ctl[CTL_YIN] = 1'b1;
              end
              S_T5: begin
                ctl[CTL_COUT] = 1'b1; ctl[CTL_ZLOWIN] = 1'b1;
                alu_op = OP_ADD;
              end
              default: begin
                ctl[CTL_ZLOWOUT] = 1'b1;
                ctl[CTL_PCIN]    = con_ff;
                step_done = 1'b1;
              end
            endcase
          end
          CLS_JR: begin
            ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_PCIN] = 1'b1;
            step_done = 1'b1;
          end
          CLS_JAL: begin
            if (state_q == S_T3) begin
              ctl[CTL_PCOUT] = 1'b1; ctl[CTL_GRB] = 1'b1; ctl[CTL_RIN] = 1'b1;
            end else begin
              ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_PCIN] = 1'b1;
              step_done = 1'b1;
            end
          end
          CLS_IO: begin
            ctl[CTL_GRA] = 1'b1;
            if (op_q == OP_IN) begin
              ctl[CTL_INPORTOUT] = 1'b1; ctl[CTL_RIN] = 1'b1;
            end else begin
              ctl[CTL_ROUT] = 1'b1; ctl[CTL_OUTPORTIN] = 1'b1;
            end
            step_done = 1'b1;
          end
          CLS_MOVE: begin
            ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
            if (op_q == OP_MFHI) ctl[CTL_HIOUT] = 1'b1;
            else                 ctl[CTL_LOOUT] = 1'b1;
            step_done = 1'b1;
          end
          CLS_HALT: state_d = S_HALT;
          default:  step_done = 1'b1;
        endcase
        // T7 is the last possible step, so it always finishes the instruction.
        if (state_q == S_T7) step_done = 1'b1;
        if (step_done) state_d = stop ? S_HALT : S_T0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: per-step control patterns,
// instruction latencies, halt/stop behaviour and mid-instruction reset.
module tb_control_unit;
  import cpu_ctl_pkg::*;

  logic             clk    = 1'b0;
  logic             clr    = 1'b0;
  logic [31:0]      ir     = '0;
  logic             con_ff = 1'b0;
  logic             stop   = 1'b0;
  logic [CTL_W-1:0] ctl;
  logic [OPW-1:0]   alu_op;
  logic             run;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk    (clk),
    .clr    (clr),
    .ir     (ir),
    .con_ff (con_ff),
    .stop   (stop),
    .ctl    (ctl),
    .alu_op (alu_op),
    .run    (run)
  );

  typedef struct {
    logic [OPW-1:0]   op;
    logic             con;
    int               step;
    logic [CTL_W-1:0] ctl;
    logic [OPW-1:0]   alu;
  } vec_t;

  typedef struct {
    logic [OPW-1:0] op;
    int             cycles;
  } lat_t;

  vec_t vecs[$];
  lat_t lats[$];
  logic [CTL_W-1:0] t0m, t1m, t2m;

  function automatic logic [CTL_W-1:0] s(int i);
    logic [CTL_W-1:0] one;
    one = {{(CTL_W-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reset, load ir, release; returns at the negedge where the FSM sits in T0.
  task automatic start(input logic [OPW-1:0] op, input logic con);
    @(negedge clk);
    clr    = 1'b0;
    stop   = 1'b0;
    con_ff = con;
    ir     = {op, 27'h0880000};
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    t0m = s(CTL_PCOUT) | s(CTL_MARIN) | s(CTL_INCPC) | s(CTL_ZLOWIN);
    t1m = s(CTL_ZLOWOUT) | s(CTL_PCIN) | s(CTL_READ) | s(CTL_MDRIN);
    t2m = s(CTL_MDROUT) | s(CTL_IRIN);

    vecs.push_back('{OP_JR,   1'b0, 0, t0m, 5'd0});
    vecs.push_back('{OP_JR,   1'b0, 1, t1m, 5'd0});
    vecs.push_back('{OP_JR,   1'b0, 2, t2m, 5'd0});
    vecs.push_back('{OP_JR,   1'b0, 3, s(CTL_GRA) | s(CTL_ROUT) | s(CTL_PCIN), 5'd0});
    vecs.push_back('{OP_ADD,  1'b0, 3, s(CTL_GRB) | s(CTL_ROUT) | s(CTL_YIN), 5'd0});
    vecs.push_back('{OP_ADD,  1'b0, 4, s(CTL_GRC) | s(CTL_ROUT) | s(CTL_ZLOWIN), 5'b00011});
    vecs.push_back('{OP_ADD,  1'b0, 5, s(CTL_ZLOWOUT) | s(CTL_GRA) | s(CTL_RIN), 5'd0});
    vecs.push_back('{OP_OR,   1'b0, 4, s(CTL_GRC) | s(CTL_ROUT) | s(CTL_ZLOWIN), 5'b01010});
    vecs.push_back('{OP_ADDI, 1'b0, 4, s(CTL_COUT) | s(CTL_ZLOWIN), 5'b01011});
    vecs.push_back('{OP_NEG,  1'b0, 3, s(CTL_GRB) | s(CTL_ROUT) | s(CTL_ZLOWIN), 5'b10000});
    vecs.push_back('{OP_NOT,  1'b0, 4, s(CTL_ZLOWOUT) | s(CTL_GRA) | s(CTL_RIN), 5'd0});
    vecs.push_back('{OP_BR,   1'b0, 3, s(CTL_GRA) | s(CTL_ROUT) | s(CTL_CONIN), 5'd0});
    vecs.push_back('{OP_BR,   1'b0, 5, s(CTL_COUT) | s(CTL_ZLOWIN), 5'b00011});
    vecs.push_back('{OP_BR,   1'b0, 6, s(CTL_ZLOWOUT), 5'd0});
    vecs.push_back('{OP_BR,   1'b1, 6, s(CTL_ZLOWOUT) | s(CTL_PCIN), 5'd0});
    vecs.push_back('{OP_LD,   1'b0, 4, s(CTL_COUT) | s(CTL_ZLOWIN), 5'b00011});
    vecs.push_back('{OP_LD,   1'b0, 6, s(CTL_READ) | s(CTL_MDRIN), 5'd0});
    vecs.push_back('{OP_LD,   1'b0, 7, s(CTL_MDROUT) | s(CTL_GRA) | s(CTL_RIN), 5'd0});
    vecs.push_back('{OP_ST,   1'b0, 5, s(CTL_ZLOWOUT) | s(CTL_MARIN), 5'd0});
    vecs.push_back('{OP_ST,   1'b0, 6, s(CTL_GRA) | s(CTL_ROUT) | s(CTL_MDRIN), 5'd0});
    vecs.push_back('{OP_ST,   1'b0, 7, s(CTL_WRITE), 5'd0});
    vecs.push_back('{OP_LDI,  1'b0, 5, s(CTL_ZLOWOUT) | s(CTL_GRA) | s(CTL_RIN), 5'd0});
    vecs.push_back('{OP_JAL,  1'b0, 3, s(CTL_PCOUT) | s(CTL_GRB) | s(CTL_RIN), 5'd0});
    vecs.push_back('{OP_JAL,  1'b0, 4, s(CTL_GRA) | s(CTL_ROUT) | s(CTL_PCIN), 5'd0});
    vecs.push_back('{OP_IN,   1'b0, 3, s(CTL_INPORTOUT) | s(CTL_GRA) | s(CTL_RIN), 5'd0});
    vecs.push_back('{OP_OUT,  1'b0, 3, s(CTL_GRA) | s(CTL_ROUT) | s(CTL_OUTPORTIN), 5'd0});
    vecs.push_back('{OP_MFHI, 1'b0, 3, s(CTL_HIOUT) | s(CTL_GRA) | s(CTL_RIN), 5'd0});
    vecs.push_back('{OP_MFLO, 1'b0, 3, s(CTL_LOOUT) | s(CTL_GRA) | s(CTL_RIN), 5'd0});
    vecs.push_back('{OP_NOP,  1'b0, 3, '0, 5'd0});
    vecs.push_back('{5'b11111, 1'b0, 3, '0, 5'd0});
`ifdef CU_MULDIV_EN
    vecs.push_back('{OP_MUL,  1'b0, 4, s(CTL_GRB) | s(CTL_ROUT) | s(CTL_ZHIGHIN) | s(CTL_ZLOWIN), 5'b01110});
    vecs.push_back('{OP_DIV,  1'b0, 6, s(CTL_ZHIGHOUT) | s(CTL_HIIN), 5'd0});
`else
    vecs.push_back('{OP_MUL,  1'b0, 3, '0, 5'd0});
    vecs.push_back('{OP_DIV,  1'b0, 3, '0, 5'd0});
`endif

    lats.push_back('{OP_JR, 4});   lats.push_back('{OP_IN, 4});
    lats.push_back('{OP_MFLO, 4}); lats.push_back('{OP_NOP, 4});
    lats.push_back('{5'b11101, 4});
    lats.push_back('{OP_JAL, 5});  lats.push_back('{OP_NEG, 5});
    lats.push_back('{OP_ADD, 6});  lats.push_back('{OP_ORI, 6});
    lats.push_back('{OP_LDI, 6});  lats.push_back('{OP_BR, 7});
    lats.push_back('{OP_LD, 8});   lats.push_back('{OP_ST, 8});
`ifdef CU_MULDIV_EN
    lats.push_back('{OP_MUL, 7});
`else
    lats.push_back('{OP_MUL, 4});
`endif

    // Reset state while clr is held low.
    @(negedge clk);
    check("reset ctl", 32'(ctl), 32'h0);
    check("reset alu_op", 32'(alu_op), 32'h0);
    check("reset run", 32'(run), 32'h0);

    foreach (vecs[i]) begin
      start(vecs[i].op, vecs[i].con);
      repeat (vecs[i].step) @(negedge clk);
      check($sformatf("vec%0d op=%b step=T%0d ctl", i, vecs[i].op, vecs[i].step),
            32'(ctl), 32'(vecs[i].ctl));
      check($sformatf("vec%0d op=%b step=T%0d alu_op", i, vecs[i].op, vecs[i].step),
            32'(alu_op), 32'(vecs[i].alu));
    end

    foreach (lats[i]) begin
      start(lats[i].op, 1'b0);
      check($sformatf("lat%0d op=%b run in T0", i, lats[i].op), 32'(run), 32'h1);
      repeat (lats[i].cycles) @(negedge clk);
      check($sformatf("lat%0d op=%b back in T0 after %0d", i, lats[i].op, lats[i].cycles),
            32'(ctl), 32'(t0m));
    end

    // ld: Read pulses in T1 and T6 only.
    start(OP_LD, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("ld Read step%0d", k), 32'(ctl[CTL_READ]), 32'((k == 1) || (k == 6)));
    end

    // st: Write pulses in T7 only.
    start(OP_ST, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("st Write step%0d", k), 32'(ctl[CTL_WRITE]), 32'(k == 7));
    end

    // ir changes after T2 must not affect the latched opcode.
    start(OP_ADD, 1'b0);
    repeat (3) @(negedge clk);
    ir = {OP_SUB, 27'h0};
    @(negedge clk);
    check("ir change T4 alu_op", 32'(alu_op), 32'(OP_ADD));
    repeat (2) @(negedge clk);
    check("ir change back to T0", 32'(ctl), 32'(t0m));

    // halt: run high in T3, low for the following 20 cycles.
    start(OP_HALT, 1'b0);
    repeat (3) @(negedge clk);
    check("halt run in T3", 32'(run), 32'h1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("halt run cycle%0d", k), 32'(run), 32'h0);
    end
    check("halt ctl", 32'(ctl), 32'h0);

    // stop raised mid-add: add completes, then HALT.
    start(OP_ADD, 1'b0);
    @(negedge clk);
    stop = 1'b1;
    repeat (4) @(negedge clk);
    check("stop add T5 ctl", 32'(ctl), 32'(s(CTL_ZLOWOUT) | s(CTL_GRA) | s(CTL_RIN)));
    check("stop add T5 run", 32'(run), 32'h1);
    @(negedge clk);
    check("stop halted run", 32'(run), 32'h0);
    check("stop halted ctl", 32'(ctl), 32'h0);
    stop = 1'b0;

    // clr pulsed during ld T6.
    start(OP_LD, 1'b0);
    repeat (6) @(negedge clk);
    check("rst-ld T6 ctl", 32'(ctl), 32'(s(CTL_READ) | s(CTL_MDRIN)));
    #1 clr = 1'b0;
    #1;
    check("rst-ld async ctl", 32'(ctl), 32'h0);
    check("rst-ld async run", 32'(run), 32'h0);
    check("rst-ld async alu_op", 32'(alu_op), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst-ld no Write/Rin %0d", k),
            32'(ctl & (s(CTL_WRITE) | s(CTL_RIN))), 32'h0);
    end
    clr = 1'b1;
    @(negedge clk);
    check("rst-ld T0 after release", 32'(ctl), 32'(t0m));
    check("rst-ld run after release", 32'(run), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
